// File: rtl/gpio_ahb_mst.sv
// Two-requester AHB-lite master with round-robin arbitration for single GPIO register accesses.
// Optional DATA-phase timeout abort is enabled by defining GPIO_MST_TIMEOUT_EN.
module gpio_ahb_mst #(
  parameter int tmo_cyc = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [9:0]  req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [4:0]  haddr,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  output logic        hwrite,
  output logic [1:0]  htrans,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hsel,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        last;
  logic        owner;
  logic        cap_write;
  logic [4:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  grant;
  logic        accept_any;
  logic        accept_idx;
  logic        data_done;
  logic        tmo_hit;

  // A tie goes to the requester that was not served last.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  assign req_ready  = (state == IDLE) ? grant : 2'b00;
  assign accept_any = |(req_valid & req_ready);
  assign accept_idx = req_ready[1];
  assign data_done  = (state == DATA) && hready;
  assign hsize      = 3'b010;
  assign hburst     = 3'b000;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

`ifdef GPIO_MST_TIMEOUT_EN
  localparam logic [7:0] tmo_lim = 8'(tmo_cyc);
  logic [7:0] wait_cnt;

  // Counts stalled DATA cycles; a completing hready always wins over the abort.
  always_ff @(posedge hclk) begin
    if (hreset || (state == ADDR)) begin
      wait_cnt <= 8'd0;
    end else if ((state == DATA) && !hready && (wait_cnt != tmo_lim)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign tmo_hit = (state == DATA) && !hready && (wait_cnt == tmo_lim);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    hsel      = 1'b0;
    htrans    = 2'b00;
    haddr     = 5'd0;
    hwrite    = 1'b0;
    hwdata    = 32'd0;
    rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (accept_any) begin
          state_nx = ADDR;
        end
      end
      ADDR: begin
        hsel     = 1'b1;
        htrans   = 2'b10;
        haddr    = cap_addr;
        hwrite   = cap_write;
        hwdata   = cap_wdata;
        state_nx = DATA;
      end
      DATA: begin
        hwdata = cap_wdata;
        if (data_done || tmo_hit) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        state_nx  = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Request capture on acceptance, response capture at the end of DATA.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      last      <= 1'b1;
      owner     <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= 5'd0;
      cap_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (accept_any) begin
        last      <= accept_idx;
        owner     <= accept_idx;
        cap_write <= accept_idx ? req_write[1] : req_write[0];
        cap_addr  <= accept_idx ? req_addr[9:5] : req_addr[4:0];
        cap_wdata <= accept_idx ? req_wdata[63:32] : req_wdata[31:0];
      end
      if (data_done) begin
        rdata_q <= cap_write ? 32'd0 : hrdata;
        err_q   <= (hresp != 2'b00);
      end else if (tmo_hit) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b1;
      end
    end
  end

  a_rsp_onehot : assert property (@(posedge hclk) disable iff (hreset)
    !(rsp_valid[0] && rsp_valid[1]));
  a_rsp_ready_excl : assert property (@(posedge hclk) disable iff (hreset)
    !((|rsp_valid) && (|req_ready)));
  a_tmo_range : assert property (@(posedge hclk)
    (tmo_cyc >= 1) && (tmo_cyc <= 255));

endmodule

// File: tb/tb_gpio_ahb_mst.sv
// Scoreboard bench for gpio_ahb_mst: directed requests push expected responses, a monitor pops them.
// Define GPIO_MST_TIMEOUT_EN for both RTL and bench to cover the timeout abort.
module tb_gpio_ahb_mst;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [9:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [4:0]  haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'd0;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hsel;
  logic        hready = 1'b0;
  logic [1:0]  hresp = 2'b00;

  typedef struct {
    logic [1:0]  onehot;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          slv_waits = 0;
  logic [31:0] slv_rdata = 32'd0;
  logic [1:0]  slv_resp = 2'b00;
  int          wleft = 0;
  bit          in_data = 1'b0;

  gpio_ahb_mst #(.tmo_cyc(4)) dut (
    .hclk(hclk), .hreset(hreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata), .hwrite(hwrite),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .hsel(hsel),
    .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int idx, input logic [31:0] rdata, input logic err, input int rcyc);
    exp_t e;
    e.onehot = (idx == 1) ? 2'b10 : 2'b01;
    e.rdata  = rdata;
    e.err    = err;
    e.cyc    = rcyc;
    sb.push_back(e);
  endtask

  // Slave model: the hready value set at a DATA cycle's negedge is the one sampled at that cycle's end.
  always @(negedge hclk) begin
    if (hsel) begin
      wleft   = slv_waits;
      in_data = 1'b1;
      hready  = 1'b0;
      hrdata  = 32'd0;
      hresp   = 2'b00;
    end else if (in_data) begin
      if (wleft == 0) begin
        hready  = 1'b1;
        hrdata  = slv_rdata;
        hresp   = slv_resp;
        in_data = 1'b0;
      end else begin
        wleft--;
        hready = 1'b0;
      end
    end else begin
      hready = 1'b0;
      hrdata = 32'd0;
      hresp  = 2'b00;
    end
  end

  // Response monitor: every rsp_valid pulse must match the oldest expected entry.
  always @(negedge hclk) begin
    if (rsp_valid != 2'b00) begin
      checkOutput("rsp_vs_req_ready", {30'd0, rsp_valid & req_ready}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: rsp_valid=%b, required no response (cycle %0d)", rsp_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rsp_valid", {30'd0, rsp_valid}, {30'd0, mon_e.onehot});
        checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
        checkOutput("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic applyStimulus(input int idx, input logic wr, input logic [4:0] addr,
                               input logic [31:0] wdata, input int waits,
                               input logic [31:0] srdata, input logic [1:0] sresp,
                               input bit expect_rsp, input logic [31:0] exp_rdata,
                               input logic exp_err, input int exp_lat, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge hclk);
    slv_waits = waits;
    slv_rdata = srdata;
    slv_resp  = sresp;
    req_write[idx]          = wr;
    req_addr[idx*5 +: 5]    = addr;
    req_wdata[idx*32 +: 32] = wdata;
    req_valid[idx]          = 1'b1;
    for (int n = 0; n < 40 && !got; n++) begin
      #1;
      if (req_ready[idx]) begin
        got = 1'b1;
        acc = cyc;
      end else begin
        @(negedge hclk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: requester %0d not accepted, required acceptance", idx);
      req_valid[idx] = 1'b0;
    end else begin
      if (expect_rsp) pushExp(idx, exp_rdata, exp_err, acc + exp_lat);
      @(negedge hclk);
      req_valid[idx] = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge hclk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge hclk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_hsel"}, {31'd0, hsel}, 32'd0);
    checkOutput({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
    checkOutput({tag, "_haddr"}, {27'd0, haddr}, 32'd0);
    checkOutput({tag, "_hwrite"}, {31'd0, hwrite}, 32'd0);
    checkOutput({tag, "_hwdata"}, hwdata, 32'd0);
    checkOutput({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    checkOutput({tag, "_hsize"}, {29'd0, hsize}, 32'd2);
    checkOutput({tag, "_hburst"}, {29'd0, hburst}, 32'd0);
  endtask

  initial begin
    int acc;
    int g_idx[$];
    int g_cyc[$];
    hreset    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 10'd0;
    req_wdata = 64'd0;
    repeat (3) @(negedge hclk);
    checkAllZero("reset");
    hreset = 1'b0;

    $display("[TB] write from requester 0");
    applyStimulus(0, 1'b1, 5'h04, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 2'b00, 1'b1, 32'd0, 1'b0, 3, acc);
    checkOutput("addr_hsel", {31'd0, hsel}, 32'd1);
    checkOutput("addr_htrans", {30'd0, htrans}, 32'd2);
    checkOutput("addr_haddr", {27'd0, haddr}, 32'h04);
    checkOutput("addr_hwrite", {31'd0, hwrite}, 32'd1);
    @(negedge hclk);
    checkOutput("data_hwdata", hwdata, 32'h0000_00A5);
    checkOutput("data_hsel", {31'd0, hsel}, 32'd0);
    checkOutput("data_htrans", {30'd0, htrans}, 32'd0);
    waitDrain();

    $display("[TB] read from requester 1");
    applyStimulus(1, 1'b0, 5'h00, 32'h0, 0, 32'h0000_005A, 2'b00, 1'b1, 32'h0000_005A, 1'b0, 3, acc);
    checkOutput("rd_haddr", {27'd0, haddr}, 32'h00);
    checkOutput("rd_hwrite", {31'd0, hwrite}, 32'd0);
    waitDrain();

    $display("[TB] both requesters valid");
    @(negedge hclk);
    slv_waits = 0;
    slv_rdata = 32'h0;
    slv_resp  = 2'b00;
    req_write = 2'b11;
    req_addr  = {5'h11, 5'h10};
    req_wdata = {32'h1111_1111, 32'h2222_2222};
    req_valid = 2'b11;
    for (int n = 0; n < 40 && g_idx.size() < 4; n++) begin
      #1;
      if (req_ready != 2'b00) begin
        g_idx.push_back(req_ready[1] ? 1 : 0);
        g_cyc.push_back(cyc);
        pushExp(req_ready[1] ? 1 : 0, 32'd0, 1'b0, cyc + 3);
      end
      @(negedge hclk);
    end
    req_valid = 2'b00;
    checkOutput("rr_grant_count", g_idx.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_idx.size()) checkOutput("rr_grant_order", g_idx[i], i % 2);
      if (i > 0 && i < g_cyc.size()) checkOutput("rr_accept_spacing", g_cyc[i] - g_cyc[i-1], 32'd4);
    end
    waitDrain();

    $display("[TB] slave error response");
    applyStimulus(1, 1'b1, 5'h07, 32'h0000_0F0F, 0, 32'h0, 2'b01, 1'b1, 32'd0, 1'b1, 3, acc);
    waitDrain();

`ifdef GPIO_MST_TIMEOUT_EN
    $display("[TB] timeout abort");
    applyStimulus(0, 1'b0, 5'h02, 32'h0, 100, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'd0, 1'b1, 7, acc);
    waitDrain();
`endif

    $display("[TB] three wait states");
    applyStimulus(0, 1'b0, 5'h08, 32'h0, 3, 32'hCAFE_0001, 2'b00, 1'b1, 32'hCAFE_0001, 1'b0, 6, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      checkOutput("wait_hsel", {31'd0, hsel}, 32'd0);
      checkOutput("wait_htrans", {30'd0, htrans}, 32'd0);
    end
    waitDrain();

    $display("[TB] reset during DATA");
    applyStimulus(0, 1'b0, 5'h1F, 32'h0, 10, 32'h0000_1234, 2'b00, 1'b0, 32'd0, 1'b0, 0, acc);
    @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    checkAllZero("midreset");
    hreset = 1'b0;
    @(negedge hclk);
    req_write = 2'b11;
    req_valid = 2'b11;
    #1;
    checkOutput("tie_after_reset", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    repeat (8) @(negedge hclk);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_ahb_mst.md
# gpio_ahb_mst

Two-requester AHB-lite master that sequences single register accesses into the GPIO AHB slave. Each requester issues one write or read at a time over a valid/ready request channel and receives a one-cycle response pulse. A round-robin arbiter shares the single AHB port between the requesters. The block sits between local control logic (e.g. a CPU-less pattern engine and a debug port) and the `hsel`/`haddr` side of the GPIO slave.

## Interface
Parameters:
- `tmo_cyc`, 16: maximum DATA-phase wait cycles before timeout abort. Used only with `GPIO_MST_TIMEOUT_EN`. Range 1..255.

Ports (bit 0 = requester 0, bit 1 = requester 1; packed fields `{req1, req0}`):
- `hclk`  in  1  clock; all logic on rising edge
- `hreset`  in  1  reset; synchronous, active-high
- `req_valid`  in  2  request present
- `req_ready`  out  2  request accepted this cycle when `valid & ready`
- `req_write`  in  2  1 = write, 0 = read
- `req_addr`  in  10  5-bit register address per requester
- `req_wdata`  in  64  32-bit write data per requester
- `rsp_valid`  out  2  one-cycle response pulse to the owning requester
- `rsp_rdata`  out  32  read data; shared; valid only with `rsp_valid`
- `rsp_err`  out  1  error flag; valid only with `rsp_valid`
- `haddr`  out  5  AHB address
- `hwdata`  out  32  AHB write data
- `hrdata`  in  32  AHB read data
- `hwrite`  out  1  AHB write
- `htrans`  out  2  AHB transfer type: 2'b10 NONSEQ or 2'b00 IDLE only
- `hsize`  out  3  constant 3'b010
- `hburst`  out  3  constant 3'b000
- `hsel`  out  1  slave select
- `hready`  in  1  slave ready; sampled only in DATA
- `hresp`  in  2  slave response; nonzero = error

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: arbitrate. At most one `req_ready` bit is high: the granted requester with `req_valid` set. On `valid & ready`, capture write, addr, wdata and owner, then go to ADDR.
- Round-robin: if both requesters are valid, grant the one not served last. If one is valid, grant it. After reset the last-served pointer is set to 1, so requester 0 wins the first tie. The pointer updates on acceptance.
- ADDR (1 cycle): `hsel`=1, `htrans`=2'b10, `haddr` and `hwrite` from the capture. `hwdata` is driven from the capture starting in this cycle. Then go to DATA.
- DATA: `hsel`=0, `htrans`=2'b00, `hwdata` held.
  - Each cycle with `hready`=1: capture `hrdata` (reads; writes capture 0) and set err = (`hresp` != 0), then go to RESP.
  - If `hready`=0, stay in DATA.
- RESP (1 cycle): `rsp_valid[owner]`=1 with `rsp_rdata`/`rsp_err` from the capture, then go to IDLE.
- `rsp_rdata`/`rsp_err` hold their last values outside RESP.
- A requester may drop `req_valid` without penalty. Requests are not queued. A single transaction is outstanding at a time.
- Reset (any state, including mid-transfer): FSM to IDLE, pointer to 1. All outputs 0 except constant `hsize`/`hburst`. The aborted transfer produces no response.

## Timing
- Acceptance edge at end of cycle N. ADDR = N+1. DATA = N+2. With immediate `hready`, RESP = N+3 and IDLE = N+4.
- Minimum 4 cycles per transaction. The next `req_ready` is asserted no earlier than N+4.
- Each DATA wait cycle adds one cycle to latency.
- `req_ready` is combinational from `req_valid`, the FSM state and the pointer. All other outputs are registered or state-decoded.
- `rsp_valid` is never high for both bits. It is never high in the same cycle as `req_ready`.

## Configuration
- `GPIO_MST_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to DATA and counts DATA cycles with `hready`=0.
  - When the count reaches `tmo_cyc`, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- Undefined: no counter. DATA waits indefinitely, and `rsp_err` reflects `hresp` only.

## Test plan
- Reset, then requester 0 writes addr 5'h04 with data 32'h0000_00A5, and the slave returns `hready`=1 in DATA. Required: `hsel`/`htrans`=2'b10 at N+1; `hwdata`=32'hA5 at N+2; `rsp_valid`=2'b01 with `rsp_err`=0 at N+3.
- Requester 1 reads addr 5'h00 and the slave returns `hrdata`=32'h0000_005A. Required: `rsp_valid`=2'b10 with `rsp_rdata`=32'h5A at N+3.
- Both requesters hold valid continuously for 4 transactions. Required: grant order 0,1,0,1, with acceptances exactly 4 cycles apart.
- Slave holds `hready`=0 for 3 DATA cycles. Required: `rsp_valid` at N+6, and `hsel` stays 0 throughout the wait.
- Slave returns `hresp`=2'b01. Required: `rsp_err`=1. With the macro and `tmo_cyc`=4 and `hready` held at 0, require `rsp_err`=1 and `rsp_rdata`=0 at N+7.
- Assert `hreset` during DATA. Required: next cycle all outputs 0 and no `rsp_valid`; after release, requester 0 wins a tie.
